// File: rtl/pec_pkg.sv
// Shared definitions for the PEC entry FIFO read side.
// Holds the entry geometry (width, lane count, flag bit positions),
// the serializer state encoding and a helper that derives the index
// of the last valid byte lane of a held entry.
package pec_pkg;

    localparam int ENTRY_W    = 242;
    localparam int LANES      = 30;
    localparam int SOP_BIT    = 241;
    localparam int EOP_BIT    = 240;
    localparam int COUNT_LANE = 29;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Last lane to emit for an entry. A full entry ends on lane 29; an eop
    // entry ends on lane n-1, and an out-of-range count is treated as 29.
    function automatic logic [4:0] lastLaneOf(input logic eop, input logic [7:0] n);
        logic [4:0] last;
        if (!eop) begin
            last = 5'(LANES - 1);
        end else if ((n == 8'd0) || (n > 8'(COUNT_LANE))) begin
            last = 5'(COUNT_LANE - 1);
        end else begin
            last = 5'(n - 8'd1);
        end
        return last;
    endfunction

endpackage

// File: rtl/pec_entry_serializer_if.sv
// Bundle of the serializer's FIFO read port and byte-stream egress port.
//   iFifoEmpty / iFifoData : show-ahead FIFO head (driven by the FIFO side)
//   oFifoRe                : pop strobe back to the FIFO
//   oValid / iReady        : byte-stream handshake
//   oData / oSop / oEop    : byte and packet delimiters
//   oErr                   : malformed-entry pulse
// The slave modport is the serializer's view; master is the environment.
interface pec_entry_serializer_if;
    import pec_pkg::*;

    logic               iFifoEmpty;
    logic [ENTRY_W-1:0] iFifoData;
    logic               oFifoRe;
    logic               oValid;
    logic               iReady;
    logic [7:0]         oData;
    logic               oSop;
    logic               oEop;
    logic               oErr;

    modport slave (
        input  iFifoEmpty, iFifoData, iReady,
        output oFifoRe, oValid, oData, oSop, oEop, oErr
    );

    modport master (
        output iFifoEmpty, iFifoData, iReady,
        input  oFifoRe, oValid, oData, oSop, oEop, oErr
    );

endinterface

// File: rtl/pec_entry_serializer.sv
// Read side of the PEC 8x242 entry FIFO. Pops entries from the FIFO's
// show-ahead port into a hold register and emits them one byte per
// accepted handshake with sop/eop delimiters. The next entry is captured
// on the same edge as the last byte's handshake, so full-rate traffic has
// no idle cycle between entries.
// Ports:
//   iClk  : clock
//   iRstn : asynchronous active-low reset
//   bus   : FIFO read port + byte-stream egress (pec_entry_serializer_if.slave)
module pec_entry_serializer
    import pec_pkg::*;
(
    input  logic                     iClk,
    input  logic                     iRstn,
    pec_entry_serializer_if.slave    bus
);

    state_t             state_q, state_d;
    logic [4:0]         lane_q, lane_d;
    logic [ENTRY_W-1:0] hold_q, hold_d;
    logic               inPkt_q, inPkt_d;
    logic               err_q, err_d;

    logic [4:0]         lastLane;
    logic [7:0]         laneByte;
    logic               accept;
    logic               lastAccept;
    logic               capture;
    logic               newSop;
    logic               newEop;
    logic [7:0]         newCount;
    logic               newErr;

    assign lastLane = lastLaneOf(hold_q[EOP_BIT], hold_q[8*COUNT_LANE +: 8]);

    // 30:1 byte mux selecting the lane currently presented downstream.
    always_comb begin
        laneByte = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_q == 5'(k)) begin
                laneByte = hold_q[8*k +: 8];
            end
        end
    end

    assign accept     = (state_q == SEND) & bus.iReady;
    assign lastAccept = accept & (lane_q == lastLane);

    // Pop is combinational and gated by reset so nothing is consumed while
    // the block is held in reset; the capture happens on the same edge.
    assign capture     = iRstn & ~bus.iFifoEmpty & ((state_q == IDLE) | lastAccept);
    assign bus.oFifoRe = capture;

    // Flag decode of the FIFO head, used only when it is being captured.
    // A single malformed entry raises one pulse even if several checks trip.
    assign newSop   = bus.iFifoData[SOP_BIT];
    assign newEop   = bus.iFifoData[EOP_BIT];
    assign newCount = bus.iFifoData[8*COUNT_LANE +: 8];
    assign newErr   = (newEop & ((newCount == 8'd0) | (newCount > 8'(COUNT_LANE))))
                    | (newSop & inPkt_q)
                    | (~newSop & ~inPkt_q);

    // Next-state logic: a capture restarts the lane counter on the new
    // entry; otherwise an accepted byte either advances the lane or, on the
    // last lane with nothing to reload, returns to IDLE. A stall holds all.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        hold_d  = hold_q;
        inPkt_d = inPkt_q;
        err_d   = 1'b0;
        if (capture) begin
            state_d = SEND;
            lane_d  = '0;
            hold_d  = bus.iFifoData;
            err_d   = newErr;
            if (newEop) begin
                inPkt_d = 1'b0;
            end else if (newSop) begin
                inPkt_d = 1'b1;
            end
        end else if (lastAccept) begin
            state_d = IDLE;
        end else if (accept) begin
            lane_d = lane_q + 5'd1;
        end
    end

    // State register; reset discards any held entry rather than resuming it.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q <= IDLE;
            lane_q  <= '0;
            hold_q  <= '0;
            inPkt_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            hold_q  <= hold_d;
            inPkt_q <= inPkt_d;
            err_q   <= err_d;
        end
    end

    assign bus.oValid = (state_q == SEND);
    assign bus.oData  = laneByte;
    assign bus.oSop   = hold_q[SOP_BIT] & (lane_q == 5'd0);
    assign bus.oEop   = hold_q[EOP_BIT] & (lane_q == lastLane);
    assign bus.oErr   = err_q;

endmodule

// File: tb/tb_pec_entry_serializer.sv
// Self-checking bench for pec_entry_serializer. A queue models the
// show-ahead FIFO, a negedge monitor records every accepted byte, and the
// recorded stream is compared with an expected stream built from the
// directed entries. Table vectors cover single entries and error cases;
// hand-written sequences cover back-to-back reload, stalls and reset.
module tb_pec_entry_serializer;
    import pec_pkg::*;

    logic iClk  = 1'b0;
    logic iRstn = 1'b0;

    pec_entry_serializer_if bus();

    pec_entry_serializer dut (
        .iClk  (iClk),
        .iRstn (iRstn),
        .bus   (bus)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    typedef struct {
        string      name;
        logic       sop;
        logic       eop;
        logic [7:0] n;
        logic [7:0] base;
        int         expBytes;
        int         expErr;
    } vec_t;

    beat_t              gotQ[$];
    beat_t              expQ[$];
    logic [ENTRY_W-1:0] fifoQ[$];
    int                 rePos[$];
    int                 errCnt  = 0;
    int                 reCnt   = 0;
    int                 curRun  = 0;
    int                 lastRun = 0;
    int                 checks   = 0;
    int                 failures = 0;
    vec_t               vecs[9];

    // Monitor: samples mid-cycle, records accepted bytes, error pulses,
    // pops (with the byte count seen so far) and runs of valid cycles.
    always @(negedge iClk) begin
        if (bus.oValid && bus.iReady) begin
            gotQ.push_back('{data: bus.oData, sop: bus.oSop, eop: bus.oEop});
        end
        if (bus.oErr) errCnt++;
        if (bus.oFifoRe) begin
            reCnt++;
            rePos.push_back(gotQ.size());
        end
        if (bus.oValid) begin
            curRun++;
        end else begin
            if (curRun > 0) lastRun = curRun;
            curRun = 0;
        end
    end

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] makeEntry(input logic sop, input logic eop,
                                                     input logic [7:0] n, input logic [7:0] base);
        logic [ENTRY_W-1:0] e;
        e = '0;
        for (int k = 0; k < LANES; k++) e[8*k +: 8] = 8'(base + k);
        if (eop) e[8*COUNT_LANE +: 8] = n;
        e[SOP_BIT] = sop;
        e[EOP_BIT] = eop;
        return e;
    endfunction

    task automatic refreshFifo();
        bus.iFifoEmpty = (fifoQ.size() == 0);
        bus.iFifoData  = (fifoQ.size() == 0) ? '0 : fifoQ[0];
    endtask

    task automatic applyStimulus(input logic sop, input logic eop, input logic [7:0] n,
                                 input logic [7:0] base);
        fifoQ.push_back(makeEntry(sop, eop, n, base));
        refreshFifo();
    endtask

    // Expected beats of one entry: 'count' bytes from base, sop on the
    // first byte if flagged, eop on the last byte if flagged.
    task automatic appendExp(input logic sop, input logic eop, input logic [7:0] base,
                             input int count, input logic endsEntry);
        for (int i = 0; i < count; i++) begin
            expQ.push_back('{data: 8'(base + i), sop: sop && (i == 0),
                             eop: eop && endsEntry && (i == count - 1)});
        end
    endtask

    // One clock: the FIFO model pops if the pop strobe was high at the edge;
    // inputs are then updated 2 time units after the rising edge.
    task automatic cycle();
        logic wasRe;
        @(negedge iClk);
        wasRe = bus.oFifoRe;
        @(posedge iClk);
        #1;
        if (wasRe && fifoQ.size() > 0) void'(fifoQ.pop_front());
        refreshFifo();
        #1;
    endtask

    task automatic waitIdle(input string name, input int budget);
        bit done = 0;
        for (int c = 0; c < budget && !done; c++) begin
            cycle();
            if (fifoQ.size() == 0 && !bus.oValid) done = 1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: actual=busy required=idle", name);
        end
        cycle();
    endtask

    task automatic waitByte(input string name, input logic [7:0] val, input int budget);
        bit found = 0;
        for (int c = 0; c < budget && !found; c++) begin
            if (bus.oValid && bus.oData == val) found = 1;
            else cycle();
        end
        if (!found) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: actual=absent required=0x%02h", name, val);
        end
    endtask

    task automatic checkStream(input string name, input int from);
        int bad = 0;
        checkOutput({name, "_len"}, gotQ.size(), expQ.size());
        for (int i = from; i < gotQ.size() && i < expQ.size(); i++) begin
            if (gotQ[i].data != expQ[i].data || gotQ[i].sop != expQ[i].sop ||
                gotQ[i].eop != expQ[i].eop) bad++;
        end
        checkOutput({name, "_stream"}, bad, 0);
    endtask

    task automatic stallAt(input string name, input logic [7:0] val);
        logic [7:0] held;
        waitByte(name, val, 60);
        held = bus.oData;
        bus.iReady = 1'b0;
        for (int s = 0; s < 2; s++) begin
            cycle();
            checkOutput({name, "_held"}, bus.oData, held);
            checkOutput({name, "_nopop"}, bus.oFifoRe, 0);
        end
        bus.iReady = 1'b1;
    endtask

    initial begin
        int g0, e0, r0;

        // name, sop, eop, n, base, expected bytes, expected error pulses
        vecs[0] = '{"sop_full",    1'b1, 1'b0, 8'd0,  8'h00, 30, 0};
        vecs[1] = '{"eop_n5",      1'b0, 1'b1, 8'd5,  8'h40,  5, 0};
        vecs[2] = '{"sop_eop_n10", 1'b1, 1'b1, 8'd10, 8'h80, 10, 0};
        vecs[3] = '{"stray_mid",   1'b0, 1'b0, 8'd0,  8'h10, 30, 1};
        vecs[4] = '{"sop_ok",      1'b1, 1'b0, 8'd0,  8'h20, 30, 0};
        vecs[5] = '{"eop_n0",      1'b0, 1'b1, 8'd0,  8'h30, 29, 1};
        vecs[6] = '{"sop_again",   1'b1, 1'b0, 8'd0,  8'h50, 30, 0};
        vecs[7] = '{"sop_in_pkt",  1'b1, 1'b1, 8'd3,  8'h60,  3, 1};
        vecs[8] = '{"stray_n40",   1'b0, 1'b1, 8'd40, 8'h70, 29, 1};

        // Reset state, with a non-empty FIFO to show the pop is gated.
        bus.iReady = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'd0, 8'h00);
        cycle();
        cycle();
        checkOutput("rst_valid", bus.oValid, 0);
        checkOutput("rst_fifo_re", bus.oFifoRe, 0);
        checkOutput("rst_err", bus.oErr, 0);
        checkOutput("rst_data", bus.oData, 0);
        checkOutput("rst_sop", bus.oSop, 0);
        checkOutput("rst_eop", bus.oEop, 0);
        checkOutput("rst_no_pop", reCnt, 0);
        fifoQ.delete();
        refreshFifo();
        iRstn = 1'b1;
        cycle();

        // Single entries, one at a time.
        for (int v = 0; v < 9; v++) begin
            g0 = gotQ.size();
            e0 = errCnt;
            r0 = reCnt;
            applyStimulus(vecs[v].sop, vecs[v].eop, vecs[v].n, vecs[v].base);
            appendExp(vecs[v].sop, vecs[v].eop, vecs[v].base, vecs[v].expBytes, 1'b1);
            waitIdle(vecs[v].name, 100);
            checkOutput({vecs[v].name, "_bytes"}, gotQ.size() - g0, vecs[v].expBytes);
            checkOutput({vecs[v].name, "_err"}, errCnt - e0, vecs[v].expErr);
            checkOutput({vecs[v].name, "_pops"}, reCnt - r0, 1);
            checkStream(vecs[v].name, g0);
        end

        // Three entries preloaded: 89 bytes with no gap, pops at 0/30/60.
        g0 = gotQ.size();
        e0 = errCnt;
        r0 = reCnt;
        applyStimulus(1'b1, 1'b0, 8'd0,  8'd0);
        applyStimulus(1'b0, 1'b0, 8'd0,  8'd30);
        applyStimulus(1'b0, 1'b1, 8'd29, 8'd60);
        appendExp(1'b1, 1'b0, 8'd0,  30, 1'b1);
        appendExp(1'b0, 1'b0, 8'd30, 30, 1'b1);
        appendExp(1'b0, 1'b1, 8'd60, 29, 1'b1);
        waitIdle("b2b", 200);
        checkOutput("b2b_bytes", gotQ.size() - g0, 89);
        checkOutput("b2b_run", lastRun, 89);
        checkOutput("b2b_pops", reCnt - r0, 3);
        checkOutput("b2b_err", errCnt - e0, 0);
        if (rePos.size() >= r0 + 3) begin
            checkOutput("b2b_pop0", rePos[r0]     - g0, 0);
            checkOutput("b2b_pop1", rePos[r0 + 1] - g0, 30);
            checkOutput("b2b_pop2", rePos[r0 + 2] - g0, 60);
        end else begin
            checkOutput("b2b_pop_count", rePos.size() - r0, 3);
        end
        checkStream("b2b", g0);

        // Stalls mid-entry and on the last lane with the next entry waiting.
        g0 = gotQ.size();
        r0 = reCnt;
        applyStimulus(1'b1, 1'b0, 8'd0, 8'hA0);
        applyStimulus(1'b0, 1'b1, 8'd4, 8'hC0);
        appendExp(1'b1, 1'b0, 8'hA0, 30, 1'b1);
        appendExp(1'b0, 1'b1, 8'hC0,  4, 1'b1);
        stallAt("stall_mid", 8'hA5);
        stallAt("stall_last", 8'hBD);
        waitIdle("stall", 100);
        checkOutput("stall_bytes", gotQ.size() - g0, 34);
        checkOutput("stall_pops", reCnt - r0, 2);
        checkStream("stall", g0);

        // Reset at lane 12 of a sop entry; the queued entry then starts clean.
        g0 = gotQ.size();
        e0 = errCnt;
        r0 = reCnt;
        applyStimulus(1'b1, 1'b0, 8'd0, 8'h10);
        applyStimulus(1'b1, 1'b1, 8'd7, 8'h40);
        appendExp(1'b1, 1'b0, 8'h10, 12, 1'b0);
        waitByte("mid_rst", 8'h1C, 60);
        iRstn = 1'b0;
        #1;
        checkOutput("mid_rst_valid", bus.oValid, 0);
        checkOutput("mid_rst_data", bus.oData, 0);
        checkOutput("mid_rst_sop", bus.oSop, 0);
        checkOutput("mid_rst_eop", bus.oEop, 0);
        checkOutput("mid_rst_fifo_re", bus.oFifoRe, 0);
        cycle();
        cycle();
        checkOutput("mid_rst_held_pops", reCnt - r0, 1);
        iRstn = 1'b1;
        appendExp(1'b1, 1'b1, 8'h40, 7, 1'b1);
        waitIdle("after_rst", 100);
        checkOutput("after_rst_bytes", gotQ.size() - g0, 19);
        checkOutput("after_rst_err", errCnt - e0, 0);
        checkOutput("after_rst_pops", reCnt - r0, 2);
        checkStream("after_rst", g0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
